// File: rtl/pixel_array_readout.sv
// pixel_array_readout
//   Sensor-side responder for the Erase/Expose/NRE_1/NRE_2/ADC control
//   sequence. It models a 2 x NUM_COLS pixel array with saturating per-pixel
//   integrators. Each rising edge of ADC digitises the selected row into a
//   small FIFO, and the FIFO streams rows downstream over valid/ready.
//   Controller protocol violations are flagged.
// Ports
//   Clk, Reset     clock, synchronous active-high reset
//   Erase, Expose  clear / integrate all pixel accumulators
//   NRE_1, NRE_2   active-low row selects (row 0 / row 1)
//   ADC            conversion strobe, one capture per rising edge
//   Light          per-pixel light increment, pixel (r,c) at slice r*NUM_COLS+c
//   Pix_data/row/valid, Pix_ready   FIFO head stream
//   Frame_done     1-cycle pulse when row 1 follows row 0 in a frame
//   Proto_err      sticky protocol violation
//   Overflow       sticky: a capture was dropped on a full FIFO

// One pixel integrator: clear wins over integrate, saturates instead of wrapping.
module pixel_acc #(
    parameter int PIX_W   = 8,
    parameter int LIGHT_W = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [LIGHT_W-1:0] i_light,
    output logic [PIX_W-1:0]   o_acc
);
    logic [PIX_W-1:0] r_acc;
    logic [PIX_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {{(PIX_W+1-LIGHT_W){1'b0}}, i_light};
    assign o_acc = r_acc;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_sum[PIX_W] ? {PIX_W{1'b1}} : w_sum[PIX_W-1:0];
    end
endmodule

module pixel_array_readout #(
    parameter int NUM_COLS   = 2,
    parameter int PIX_W      = 8,
    parameter int LIGHT_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Erase,
    input  logic                          Expose,
    input  logic                          NRE_1,
    input  logic                          NRE_2,
    input  logic                          ADC,
    input  logic [2*NUM_COLS*LIGHT_W-1:0] Light,
    output logic [NUM_COLS*PIX_W-1:0]     Pix_data,
    output logic                          Pix_row,
    output logic                          Pix_valid,
    input  logic                          Pix_ready,
    output logic                          Frame_done,
    output logic                          Proto_err,
    output logic                          Overflow
);
    localparam int NPIX  = 2 * NUM_COLS;
    localparam int ROW_W = NUM_COLS * PIX_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic             row;
        logic [ROW_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_EXPOSING, S_READ_R0, S_READ_R1} state_t;

    // ---------------- pixel array ----------------
    logic [NPIX-1:0][PIX_W-1:0] w_acc;

    for (genvar g = 0; g < NPIX; g++) begin : g_pix
        pixel_acc #(.PIX_W(PIX_W), .LIGHT_W(LIGHT_W)) u_pix (
            .Clk     (Clk),
            .Reset   (Reset),
            .i_clr   (Erase),
            .i_en    (Expose),
            .i_light (Light[g*LIGHT_W +: LIGHT_W]),
            .o_acc   (w_acc[g])
        );
    end

    // ---------------- capture decode ----------------
    logic   r_adc_prev;
    logic   w_sel0, w_sel1, w_both_low, w_edge, w_cap, w_bad_edge;
    entry_t w_cap_entry;

    assign w_sel0     = ~NRE_1 &  NRE_2;
    assign w_sel1     =  NRE_1 & ~NRE_2;
    assign w_both_low = ~NRE_1 & ~NRE_2;
    assign w_edge     = ADC & ~r_adc_prev;
    assign w_cap      = w_edge & (w_sel0 | w_sel1) & ~Expose;
    assign w_bad_edge = w_edge & ~w_cap;

    // Accumulator value before this edge's update is what gets converted.
    assign w_cap_entry.row  = w_sel1;
    assign w_cap_entry.data = w_sel1 ? w_acc[NPIX-1:NUM_COLS] : w_acc[NUM_COLS-1:0];

    // ---------------- row FIFO ----------------
    entry_t [FIFO_DEPTH-1:0] r_mem;
    logic   [AW-1:0]         r_wr, r_rd;
    logic   [AW:0]           r_count;
    logic                    w_full, w_pop, w_push;
    entry_t                  w_head;

    assign Pix_valid = (r_count != '0);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = Pix_valid & Pix_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push    = w_cap & (~w_full | w_pop);
    assign w_head    = r_mem[r_rd];
    assign Pix_data  = Pix_valid ? w_head.data : '0;
    assign Pix_row   = Pix_valid & w_head.row;

    always_ff @(posedge Clk) begin
        if (w_push && !Reset)
            r_mem[r_wr] <= w_cap_entry;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // ---------------- frame FSM + sticky flags ----------------
    state_t r_state;
    logic   r_frame_done, r_proto_err, r_overflow;
    logic   w_seq_err;

    assign w_seq_err = w_cap & (((r_state == S_EXPOSING) & w_sel1) |
                                ((r_state == S_READ_R0)  & w_sel0));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
            r_proto_err  <= 1'b0;
            r_overflow   <= 1'b0;
            // Treat ADC as already high so a level held across reset
            // release is not mistaken for a fresh strobe.
            r_adc_prev   <= 1'b1;
        end else begin
            r_adc_prev   <= ADC;
            r_frame_done <= 1'b0;
            if (w_both_low || w_bad_edge || w_seq_err)
                r_proto_err <= 1'b1;
            if (w_cap && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (Erase) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:      if (Expose) r_state <= S_EXPOSING;
                    S_EXPOSING:  if (w_cap && w_sel0) r_state <= S_READ_R0;
                    S_READ_R0: begin
                        if (w_cap && w_sel1) begin
                            r_state      <= S_READ_R1;
                            r_frame_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Frame_done = r_frame_done;
    assign Proto_err  = r_proto_err;
    assign Overflow   = r_overflow;
endmodule

// File: tb/tb_pixel_array_readout.sv
module tb_pixel_array_readout;
    localparam int NC = 2, PW = 8, LW = 4, FD = 4;
    localparam int RW = NC * PW;

    logic            Clk = 1'b0;
    logic            Reset, Erase, Expose, NRE_1, NRE_2, ADC, Pix_ready;
    logic [2*NC*LW-1:0] Light;
    logic [RW-1:0]   Pix_data;
    logic            Pix_row, Pix_valid, Frame_done, Proto_err, Overflow;

    pixel_array_readout #(.NUM_COLS(NC), .PIX_W(PW), .LIGHT_W(LW), .FIFO_DEPTH(FD)) dut (
        .Clk(Clk), .Reset(Reset), .Erase(Erase), .Expose(Expose),
        .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC), .Light(Light),
        .Pix_data(Pix_data), .Pix_row(Pix_row), .Pix_valid(Pix_valid),
        .Pix_ready(Pix_ready), .Frame_done(Frame_done),
        .Proto_err(Proto_err), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: arrays of pixel sums, a queue of rows, frame progress ----
    int            m_acc[2][NC];
    logic [RW:0]   m_q[$];
    bit            m_prev, m_fd, m_perr, m_ovf;
    int            m_phase;   // 0 idle, 1 exposing, 2 row0 read, 3 row1 read

    task automatic model_step();
        bit edge_, cap, pop;
        int sel, v;
        logic [RW:0] ent;
        if (Reset) begin
            foreach (m_acc[r, c]) m_acc[r][c] = 0;
            m_q.delete();
            m_prev = 1; m_phase = 0; m_fd = 0; m_perr = 0; m_ovf = 0;
            return;
        end
        edge_ = ADC && !m_prev;
        sel = (!NRE_1 && NRE_2) ? 0 : (NRE_1 && !NRE_2) ? 1 : -1;
        cap = edge_ && sel >= 0 && !Expose;
        if (!NRE_1 && !NRE_2) m_perr = 1;
        if (edge_ && !cap) m_perr = 1;
        if (cap && ((m_phase == 1 && sel == 1) || (m_phase == 2 && sel == 0))) m_perr = 1;
        ent = '0;
        if (cap) begin
            ent[RW] = (sel == 1);
            for (int c = 0; c < NC; c++) ent[c*PW +: PW] = m_acc[sel][c][PW-1:0];
        end
        pop = (m_q.size() > 0) && Pix_ready;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < FD) m_q.push_back(ent);
            else m_ovf = 1;
        end
        m_fd = 0;
        if (Erase) m_phase = 0;
        else if (m_phase == 0 && Expose) m_phase = 1;
        else if (m_phase == 1 && cap && sel == 0) m_phase = 2;
        else if (m_phase == 2 && cap && sel == 1) begin m_phase = 3; m_fd = 1; end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) begin
                if (Erase) m_acc[r][c] = 0;
                else if (Expose) begin
                    v = m_acc[r][c] + int'(Light[(r*NC+c)*LW +: LW]);
                    m_acc[r][c] = (v > 255) ? 255 : v;
                end
            end
        m_prev = ADC;
    endtask

    task automatic check_all();
        bit v;
        v = m_q.size() != 0;
        chk("valid", Pix_valid, v);
        chk("row",   Pix_row,   v ? m_q[0][RW] : 1'b0);
        chk("data",  Pix_data,  v ? m_q[0][RW-1:0] : '0);
        chk("fdone", Frame_done, m_fd);
        chk("perr",  Proto_err,  m_perr);
        chk("ovf",   Overflow,   m_ovf);
    endtask

    task automatic cyc(input bit e, input bit x, input bit n1, input bit n2,
                       input bit a, input bit rdy);
        Erase = e; Expose = x; NRE_1 = n1; NRE_2 = n2; ADC = a; Pix_ready = rdy;
        model_step();
        @(posedge Clk); #1;
        check_all();
    endtask

    task automatic rst(input bit a);
        Reset = 1; cyc(0, 0, 1, 1, a, 0); Reset = 0;
    endtask

    task automatic set_light(input int val);
        for (int p = 0; p < 2*NC; p++) Light[p*LW +: LW] = val[LW-1:0];
    endtask

    initial begin
        Reset = 1; Erase = 0; Expose = 0; NRE_1 = 1; NRE_2 = 1; ADC = 0; Pix_ready = 0;
        Light = '0;
        rst(0); rst(0);
        chk("rst_valid", Pix_valid, 0);
        chk("rst_data",  Pix_data, 0);

        // T1: light 3 for 5 cycles, row 0 conversion
        set_light(3);
        repeat (5) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t1_valid", Pix_valid, 1);
        chk("t1_row",   Pix_row, 0);
        chk("t1_data",  Pix_data, 32'h0F0F);

        // T2: saturation to 255, row 1 capture
        set_light(15);
        cyc(1, 0, 1, 1, 0, 1);
        repeat (20) cyc(0, 1, 1, 1, 0, 1);
        cyc(0, 0, 1, 0, 1, 0);
        chk("t2_row",  Pix_row, 1);
        chk("t2_data", Pix_data, 32'hFFFF);

        // T3: full frame, Frame_done exactly once
        rst(0);
        set_light(2);
        cyc(1, 0, 1, 1, 0, 1);
        repeat (3) cyc(0, 1, 1, 1, 0, 1);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 0, 1);
        chk("t3_fd_early", Frame_done, 0);
        cyc(0, 0, 1, 0, 1, 1);
        chk("t3_fd", Frame_done, 1);
        chk("t3_perr", Proto_err, 0);
        cyc(0, 0, 1, 1, 0, 1);
        chk("t3_fd_once", Frame_done, 0);

        // T4: fill past depth with downstream stalled, then drain in order
        rst(0);
        set_light(1);
        repeat (2) cyc(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, i % 2, (i + 1) % 2, 1, 0);
            cyc(0, 0, 1, 1, 0, 0);
        end
        chk("t4_ovf", Overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_row", Pix_row, i % 2);
            cyc(0, 0, 1, 1, 0, 1);
        end
        chk("t4_empty", Pix_valid, 0);

        // T5: both selects low on a strobe; Erase beats Expose
        rst(0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t5_perr", Proto_err, 1);
        chk("t5_valid", Pix_valid, 0);
        set_light(9);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t5_zero", Pix_data, 0);
        chk("t5_zero_valid", Pix_valid, 1);

        // T6: reset mid-frame with 2 entries, ADC held high through release
        rst(0);
        set_light(4);
        repeat (2) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t6_pre_valid", Pix_valid, 1);
        rst(1);
        chk("t6_valid", Pix_valid, 0);
        chk("t6_perr",  Proto_err, 0);
        chk("t6_fd",    Frame_done, 0);
        repeat (3) cyc(0, 0, 0, 1, 1, 1);
        chk("t6_nocap", Pix_valid, 0);

        // Randomised traffic, periodic resets to keep sticky flags informative
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) rst($urandom_range(0, 1));
            Light = $urandom;
            begin
                bit e, x, n1, n2, a, r;
                int s;
                e = ($urandom_range(0, 19) == 0);
                x = ($urandom_range(0, 2) == 0);
                s = $urandom_range(0, 39);
                n1 = (s < 19) ? 0 : 1;
                n2 = (s < 19) ? 1 : (s < 38) ? 0 : (s == 38);
                if (s == 39) n1 = 0;
                a = ($urandom_range(0, 2) == 0) ? ~ADC : ADC;
                r = $urandom_range(0, 1);
                cyc(e, x, n1, n2, a, r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
